// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave byte interface.
//   SPI_DATA_W      - default bits per SPI byte
//   AES_BLOCK_BYTES - default bytes per AES block
//   spi_state_t     - frame FSM state encoding
//   byte_idx_t      - byte index within an AES block
package spi_pkg;

    localparam int unsigned SPI_DATA_W      = 8;
    localparam int unsigned AES_BLOCK_BYTES = 16;
    localparam int unsigned BYTE_IDX_W      = $clog2(AES_BLOCK_BYTES);

    typedef enum logic {
        SPI_IDLE,
        SPI_SHIFT
    } spi_state_t;

    typedef logic [BYTE_IDX_W-1:0] byte_idx_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Pin synchroniser with registered edge pulses.
//   clk, n_rst - system clock, asynchronous active-low reset
//   d          - raw asynchronous pin
//   level      - synchronised pin level
//   rise, fall - registered 1-cycle pulses on a synchronised 0->1 / 1->0 transition
// STAGES must be at least 2. RESET_VAL sets the reset value of every internal flop so an
// idle-high pin (such as a slave select) does not produce an edge when reset releases.
module spi_sync_edge #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic n_rst,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              hist_q, hist_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
        hist_d = sync_q[STAGES-1];
        rise_d = sync_q[STAGES-1] & ~hist_q;
        fall_d = ~sync_q[STAGES-1] & hist_q;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync_q <= {STAGES{RESET_VAL}};
            hist_q <= RESET_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/spi_slave_byte_if.sv
// SPI mode-0 slave front end for the AES datapath.
//   clk, n_rst           - system clock (>= 4x SCK), asynchronous active-low reset
//   sclk, ss_n, mosi     - raw SPI pins
//   miso, miso_oe        - registered slave data out and its output enable
//   tx_data, tx_load     - response byte write port into a one-entry buffer
//   tx_ready             - buffer empty; tx_load only accepted while high
//   tx_underrun          - pulse when a byte boundary found the buffer empty (0x00 sent)
//   rx_data, rx_valid    - last received byte (MSB first) and its update pulse
//   block_done           - pulse with rx_valid on the last byte of each AES block
//   byte_idx             - index of the byte currently being received within the block
module spi_slave_byte_if
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W      = SPI_DATA_W,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned BLOCK_BYTES = AES_BLOCK_BYTES,
    localparam int unsigned IDX_W      = $clog2(BLOCK_BYTES),
    localparam int unsigned CNT_W      = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              sclk,
    input  logic              ss_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic              tx_ready,
    output logic              tx_underrun,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              block_done,
    output logic [IDX_W-1:0]  byte_idx
);

    logic sck_lvl, sck_rise, sck_fall;
    logic ss_lvl, ss_rise, ss_fall;
    logic mosi_s, mosi_rise, mosi_fall;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
        .clk   (clk),
        .n_rst (n_rst),
        .d     (sclk),
        .level (sck_lvl),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
        .clk   (clk),
        .n_rst (n_rst),
        .d     (ss_n),
        .level (ss_lvl),
        .rise  (ss_rise),
        .fall  (ss_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk   (clk),
        .n_rst (n_rst),
        .d     (mosi),
        .level (mosi_s),
        .rise  (mosi_rise),
        .fall  (mosi_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{sck_lvl, ss_lvl, mosi_rise, mosi_fall};

    spi_state_t        state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [IDX_W-1:0]  byte_idx_q, byte_idx_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              rx_pend_q, rx_pend_d;
    logic              block_done_q, block_done_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic              boundary_q, boundary_d;
    logic              miso_q, miso_d;
    logic              miso_oe_q, miso_oe_d;
    logic [DATA_W-1:0] tx_buf_q, tx_buf_d;
    logic              tx_ready_q, tx_ready_d;
    logic              tx_underrun_q, tx_underrun_d;
    logic              reload;
    logic              last_byte;

    assign last_byte = (byte_idx_q == IDX_W'(BLOCK_BYTES - 1));

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        byte_idx_d    = byte_idx_q;
        rx_shift_d    = rx_shift_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        rx_pend_d     = 1'b0;
        block_done_d  = 1'b0;
        tx_shift_d    = tx_shift_q;
        boundary_d    = boundary_q;
        miso_d        = miso_q;
        miso_oe_d     = miso_oe_q;
        tx_buf_d      = tx_buf_q;
        tx_ready_d    = tx_ready_q;
        tx_underrun_d = 1'b0;
        reload        = 1'b0;

        unique case (state_q)
            SPI_IDLE: begin
                if (ss_fall) begin
                    state_d    = SPI_SHIFT;
                    bit_cnt_d  = '0;
                    byte_idx_d = '0;
                    boundary_d = 1'b0;
                    tx_shift_d = tx_buf_q;
                    miso_d     = tx_buf_q[DATA_W-1];
                    miso_oe_d  = 1'b1;
                    reload     = 1'b1;
                end
            end
            SPI_SHIFT: begin
                // Deselect wins over everything, including a byte still in flight.
                if (ss_rise) begin
                    state_d    = SPI_IDLE;
                    bit_cnt_d  = '0;
                    byte_idx_d = '0;
                    boundary_d = 1'b0;
                    miso_d     = 1'b0;
                    miso_oe_d  = 1'b0;
                end else begin
                    if (rx_pend_q) begin
                        rx_data_d    = rx_shift_q;
                        rx_valid_d   = 1'b1;
                        block_done_d = last_byte;
                        byte_idx_d   = last_byte ? '0 : byte_idx_q + IDX_W'(1);
                    end
                    if (sck_rise) begin
                        rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_s};
                        if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                            bit_cnt_d  = '0;
                            rx_pend_d  = 1'b1;
                            boundary_d = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end
                    if (sck_fall) begin
                        if (boundary_q) begin
                            // First falling edge after a full byte starts the next response.
                            boundary_d = 1'b0;
                            if (tx_ready_q) begin
                                tx_shift_d    = '0;
                                miso_d        = 1'b0;
                                tx_underrun_d = 1'b1;
                            end else begin
                                tx_shift_d = tx_buf_q;
                                miso_d     = tx_buf_q[DATA_W-1];
                                reload     = 1'b1;
                            end
                        end else begin
                            tx_shift_d = tx_shift_q << 1;
                            miso_d     = tx_shift_q[DATA_W-2];
                        end
                    end
                end
            end
            default: state_d = SPI_IDLE;
        endcase

        // A reload empties the buffer, but a simultaneous write refills it.
        if (reload) begin
            tx_ready_d = 1'b1;
        end
        if (tx_load && (tx_ready_q || reload)) begin
            tx_buf_d   = tx_data;
            tx_ready_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= SPI_IDLE;
            bit_cnt_q     <= '0;
            byte_idx_q    <= '0;
            rx_shift_q    <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            rx_pend_q     <= 1'b0;
            block_done_q  <= 1'b0;
            tx_shift_q    <= '0;
            boundary_q    <= 1'b0;
            miso_q        <= 1'b0;
            miso_oe_q     <= 1'b0;
            tx_buf_q      <= '0;
            tx_ready_q    <= 1'b1;
            tx_underrun_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            byte_idx_q    <= byte_idx_d;
            rx_shift_q    <= rx_shift_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            rx_pend_q     <= rx_pend_d;
            block_done_q  <= block_done_d;
            tx_shift_q    <= tx_shift_d;
            boundary_q    <= boundary_d;
            miso_q        <= miso_d;
            miso_oe_q     <= miso_oe_d;
            tx_buf_q      <= tx_buf_d;
            tx_ready_q    <= tx_ready_d;
            tx_underrun_q <= tx_underrun_d;
        end
    end

    assign miso        = miso_q;
    assign miso_oe     = miso_oe_q;
    assign tx_ready    = tx_ready_q;
    assign tx_underrun = tx_underrun_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign block_done  = block_done_q;
    assign byte_idx    = byte_idx_q;

endmodule

// File: tb/tb_spi_slave_byte_if.sv
// Directed testbench for spi_slave_byte_if (clk:SCK = 8:1).
module tb_spi_slave_byte_if;

    logic       clk;
    logic       n_rst;
    logic       sclk;
    logic       ss_n;
    logic       mosi;
    logic       miso;
    logic       miso_oe;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       tx_ready;
    logic       tx_underrun;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       block_done;
    logic [3:0] byte_idx;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // Pulse monitor: outputs change on posedge, sampled on negedge.
    int         rx_cnt  = 0;
    int         und_cnt = 0;
    int         blk_cnt = 0;
    logic [7:0] rx_log  [128];
    logic       blk_log [128];

    spi_slave_byte_if #(
        .DATA_W      (8),
        .SYNC_STAGES (2),
        .BLOCK_BYTES (16)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .sclk        (sclk),
        .ss_n        (ss_n),
        .mosi        (mosi),
        .miso        (miso),
        .miso_oe     (miso_oe),
        .tx_data     (tx_data),
        .tx_load     (tx_load),
        .tx_ready    (tx_ready),
        .tx_underrun (tx_underrun),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .block_done  (block_done),
        .byte_idx    (byte_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid) begin
            if (rx_cnt < 128) begin
                rx_log[rx_cnt]  = rx_data;
                blk_log[rx_cnt] = block_done;
            end
            rx_cnt = rx_cnt + 1;
        end
        if (block_done) blk_cnt = blk_cnt + 1;
        if (tx_underrun) und_cnt = und_cnt + 1;
    end

    // Clock n bits MSB first; returns MISO as seen at each SCK rise.
    task automatic spi_bits(input logic [7:0] mo, input int n, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 0; i < n; i++) begin
            mosi = mo[7-i];
            repeat (4) @(negedge clk);
            mi[7-i] = miso;
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic select_slave();
        @(negedge clk);
        ss_n = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic deselect_slave();
        repeat (8) @(negedge clk);
        ss_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic load_tx(input logic [7:0] v);
        @(negedge clk);
        tx_data = v;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
    endtask

    task automatic test_reset();
        n_rst = 1'b0; sclk = 1'b0; ss_n = 1'b1; mosi = 1'b0;
        tx_data = 8'h00; tx_load = 1'b0;
        repeat (3) @(negedge clk);
        chk_cnt++; if (miso !== 1'b0) $display("FAIL reset_miso got %b want 0", miso); else pass_cnt++;
        chk_cnt++; if (miso_oe !== 1'b0) $display("FAIL reset_miso_oe got %b want 0", miso_oe); else pass_cnt++;
        chk_cnt++; if (tx_ready !== 1'b1) $display("FAIL reset_tx_ready got %b want 1", tx_ready); else pass_cnt++;
        chk_cnt++; if (tx_underrun !== 1'b0) $display("FAIL reset_underrun got %b want 0", tx_underrun); else pass_cnt++;
        chk_cnt++; if (rx_data !== 8'h00) $display("FAIL reset_rx_data got %h want 00", rx_data); else pass_cnt++;
        chk_cnt++; if (rx_valid !== 1'b0) $display("FAIL reset_rx_valid got %b want 0", rx_valid); else pass_cnt++;
        chk_cnt++; if (block_done !== 1'b0) $display("FAIL reset_block_done got %b want 0", block_done); else pass_cnt++;
        chk_cnt++; if (byte_idx !== 4'd0) $display("FAIL reset_byte_idx got %0d want 0", byte_idx); else pass_cnt++;
        n_rst = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_rx_byte();
        int         base;
        logic [7:0] mi;
        base = rx_cnt;
        select_slave();
        chk_cnt++; if (miso_oe !== 1'b1) $display("FAIL rx_miso_oe got %b want 1", miso_oe); else pass_cnt++;
        chk_cnt++; if (byte_idx !== 4'd0) $display("FAIL rx_idx_start got %0d want 0", byte_idx); else pass_cnt++;
        spi_bits(8'hA5, 8, mi);
        repeat (8) @(negedge clk);
        chk_cnt++; if (rx_cnt - base !== 1) $display("FAIL rx_count got %0d want 1", rx_cnt - base); else pass_cnt++;
        chk_cnt++; if (rx_log[base] !== 8'hA5) $display("FAIL rx_data got %h want a5", rx_log[base]); else pass_cnt++;
        chk_cnt++; if (blk_log[base] !== 1'b0) $display("FAIL rx_block_done got %b want 0", blk_log[base]); else pass_cnt++;
        chk_cnt++; if (byte_idx !== 4'd1) $display("FAIL rx_idx_after got %0d want 1", byte_idx); else pass_cnt++;
        deselect_slave();
        chk_cnt++; if (miso_oe !== 1'b0) $display("FAIL rx_oe_after got %b want 0", miso_oe); else pass_cnt++;
    endtask

    task automatic test_tx_byte();
        logic [7:0] mi;
        load_tx(8'h3C);
        chk_cnt++; if (tx_ready !== 1'b0) $display("FAIL tx_ready_loaded got %b want 0", tx_ready); else pass_cnt++;
        select_slave();
        chk_cnt++; if (tx_ready !== 1'b1) $display("FAIL tx_ready_ssfall got %b want 1", tx_ready); else pass_cnt++;
        spi_bits(8'h00, 8, mi);
        chk_cnt++; if (mi !== 8'h3C) $display("FAIL tx_miso_bits got %h want 3c", mi); else pass_cnt++;
        deselect_slave();
    endtask

    task automatic test_block();
        int         base;
        int         blk_base;
        int         bad;
        logic [7:0] mi;
        base     = rx_cnt;
        blk_base = blk_cnt;
        bad      = 0;
        select_slave();
        for (int i = 0; i < 16; i++) begin
            spi_bits(8'(i), 8, mi);
        end
        repeat (8) @(negedge clk);
        chk_cnt++; if (rx_cnt - base !== 16) $display("FAIL block_count got %0d want 16", rx_cnt - base); else pass_cnt++;
        for (int i = 0; i < 16; i++) begin
            if (rx_log[base+i] !== 8'(i)) bad++;
        end
        chk_cnt++; if (bad !== 0) $display("FAIL block_data got %0d bad bytes want 0", bad); else pass_cnt++;
        chk_cnt++; if (blk_cnt - blk_base !== 1) $display("FAIL block_done_count got %0d want 1", blk_cnt - blk_base); else pass_cnt++;
        chk_cnt++; if (blk_log[base+15] !== 1'b1) $display("FAIL block_done_last got %b want 1", blk_log[base+15]); else pass_cnt++;
        chk_cnt++; if (byte_idx !== 4'd0) $display("FAIL block_idx_wrap got %0d want 0", byte_idx); else pass_cnt++;
        deselect_slave();
    endtask

    task automatic test_underrun();
        int         base;
        logic [7:0] mi;
        load_tx(8'h5A);
        select_slave();
        base = und_cnt;
        spi_bits(8'h00, 8, mi);
        chk_cnt++; if (mi !== 8'h5A) $display("FAIL under_first got %h want 5a", mi); else pass_cnt++;
        repeat (6) @(negedge clk);
        chk_cnt++; if (und_cnt - base !== 1) $display("FAIL under_pulses got %0d want 1", und_cnt - base); else pass_cnt++;
        spi_bits(8'h00, 8, mi);
        chk_cnt++; if (mi !== 8'h00) $display("FAIL under_second got %h want 00", mi); else pass_cnt++;
        deselect_slave();
    endtask

    task automatic test_abort();
        int         base;
        logic [7:0] mi;
        base = rx_cnt;
        select_slave();
        spi_bits(8'hFF, 5, mi);
        deselect_slave();
        chk_cnt++; if (rx_cnt - base !== 0) $display("FAIL abort_no_valid got %0d want 0", rx_cnt - base); else pass_cnt++;
        chk_cnt++; if (miso_oe !== 1'b0) $display("FAIL abort_oe got %b want 0", miso_oe); else pass_cnt++;
        chk_cnt++; if (byte_idx !== 4'd0) $display("FAIL abort_idx got %0d want 0", byte_idx); else pass_cnt++;
        select_slave();
        spi_bits(8'h81, 8, mi);
        repeat (8) @(negedge clk);
        chk_cnt++; if (rx_cnt - base !== 1) $display("FAIL abort_next_count got %0d want 1", rx_cnt - base); else pass_cnt++;
        chk_cnt++; if (rx_log[base] !== 8'h81) $display("FAIL abort_next_data got %h want 81", rx_log[base]); else pass_cnt++;
        chk_cnt++; if (byte_idx !== 4'd1) $display("FAIL abort_next_idx got %0d want 1", byte_idx); else pass_cnt++;
        deselect_slave();
    endtask

    task automatic test_load_ignored();
        logic [7:0] mi;
        load_tx(8'h11);
        load_tx(8'h22);
        chk_cnt++; if (tx_ready !== 1'b0) $display("FAIL ign_tx_ready got %b want 0", tx_ready); else pass_cnt++;
        select_slave();
        spi_bits(8'h00, 8, mi);
        chk_cnt++; if (mi !== 8'h11) $display("FAIL ign_tx_byte got %h want 11", mi); else pass_cnt++;
        deselect_slave();
    endtask

    task automatic test_latency();
        int         n;
        logic [7:0] mi;
        select_slave();
        spi_bits(8'hF0, 7, mi);
        mosi = 1'b0;
        repeat (4) @(negedge clk);
        sclk = 1'b1;
        n = 0;
        while (rx_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        // Pin raised between posedges: posedges 0..4 -> rx_valid visible at 5th negedge.
        chk_cnt++; if (n !== 5) $display("FAIL latency got %0d want 5", n); else pass_cnt++;
        chk_cnt++; if (rx_data !== 8'hF0) $display("FAIL latency_data got %h want f0", rx_data); else pass_cnt++;
        repeat (4) @(negedge clk);
        sclk = 1'b0;
        deselect_slave();
    endtask

    task automatic test_reset_midframe();
        logic [7:0] mi;
        load_tx(8'h77);
        select_slave();
        spi_bits(8'hC0, 3, mi);
        n_rst = 1'b0;
        #1;
        chk_cnt++; if (miso_oe !== 1'b0) $display("FAIL rst_mid_oe got %b want 0", miso_oe); else pass_cnt++;
        chk_cnt++; if (tx_ready !== 1'b1) $display("FAIL rst_mid_ready got %b want 1", tx_ready); else pass_cnt++;
        ss_n = 1'b1;
        sclk = 1'b0;
        repeat (4) @(negedge clk);
        n_rst = 1'b1;
        repeat (8) @(negedge clk);
        chk_cnt++; if (miso_oe !== 1'b0) $display("FAIL rst_mid_idle got %b want 0", miso_oe); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_rx_byte();
        test_tx_byte();
        test_block();
        test_underrun();
        test_abort();
        test_load_ignored();
        test_latency();
        test_reset_midframe();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/spi_slave_byte_if.md
Name: spi_slave_byte_if

Overview:
SPI mode-0 slave front end for the AES chip. Synchronises the off-chip SCK, SS_n and MOSI pins into clk. Assembles MOSI bits MSB-first into bytes and serialises a host-supplied response byte onto MISO. Produces the per-byte and per-block (16-byte AES block) strobes that the downstream bit/byte counting and key/data loading logic consumes.

Parameters:
DATA_W, 8, bits per SPI byte
SYNC_STAGES, 2, flip-flop depth of each pin synchroniser (minimum 2)
BLOCK_BYTES, 16, bytes per AES block; sets the block_done period

Ports:
clk  in  1  system clock; must be at least 4x SCK frequency
n_rst  in  1  asynchronous active-low reset
sclk  in  1  raw SPI clock pin, CPOL=0
ss_n  in  1  raw slave-select pin, active low
mosi  in  1  raw master-out data pin
miso  out  1  slave-out data, registered
miso_oe  out  1  MISO output enable; 1 while slave selected
tx_data  in  DATA_W  next response byte
tx_load  in  1  write strobe for tx_data
tx_ready  out  1  transmit buffer empty; tx_load accepted only when 1
tx_underrun  out  1  1-cycle pulse: byte boundary reached with empty buffer
rx_data  out  DATA_W  last complete received byte, held until next byte
rx_valid  out  1  1-cycle pulse: rx_data updated
block_done  out  1  1-cycle pulse, coincident with rx_valid, on byte BLOCK_BYTES of a frame
byte_idx  out  clog2(BLOCK_BYTES)  index of the byte currently being received within the block

Behaviour:
- Reset values: miso=0, miso_oe=0, tx_ready=1, tx_underrun=0, rx_data=0, rx_valid=0, block_done=0, byte_idx=0. All synchroniser flops reset to 0, except ss_n flops, which reset to 1.
- Sync and edge detection: each pin passes through SYNC_STAGES flops. Edges are detected against one further history flop. sck_rise, sck_fall, ss_fall and ss_rise are 1-cycle pulses.
- FSM states IDLE and SHIFT.
  - IDLE->SHIFT on ss_fall: bit_cnt=0, byte_idx=0, tx shift reg loaded from buffer, miso=buffer MSB, miso_oe=1.
  - SHIFT->IDLE on ss_rise: partial byte discarded, no rx_valid, bit_cnt=0, byte_idx=0, miso=0, miso_oe=0.
  - SCK edges in IDLE are ignored.
- RX in SHIFT, on sck_rise: rx_shift <= {rx_shift[DATA_W-2:0], mosi_s}, bit_cnt++.
  - When bit_cnt==DATA_W-1, the next cycle gives rx_data=assembled byte, rx_valid=1, bit_cnt=0.
  - byte_idx increments and wraps from BLOCK_BYTES-1 to 0.
  - block_done=1 in the same cycle when the byte completed had byte_idx==BLOCK_BYTES-1.
- Latency: rx_valid is asserted SYNC_STAGES+2 clk cycles after the first clk edge that samples SCK high.
- TX in SHIFT:
  - Non-boundary sck_fall: tx shift reg shifts left and miso presents the next bit.
  - Boundary sck_fall (the first after a byte completes): reload from buffer. If the buffer is empty, load 0x00 and pulse tx_underrun.
- TX buffer:
  - tx_load while tx_ready=1 captures tx_data and drops tx_ready the next cycle.
  - tx_load while tx_ready=0 is ignored; the buffer is unchanged.
  - The reload (at ss_fall or at a byte boundary) sets tx_ready=1 in the same cycle.
  - If tx_load and a reload coincide, the reload takes the old buffer contents and the new tx_data is captured; tx_ready stays 0.
- ss_rise coinciding with the sck_rise that completes a byte: ss_rise wins and the byte is discarded.
- n_rst asserted mid-frame: immediate return to reset values. The frame resumes only after a fresh ss_fall.
- bit_cnt and byte_idx are unsigned and wrap; no saturation.

Decomposition:
- Package spi_pkg holds:
  - SPI_DATA_W=8, AES_BLOCK_BYTES=16
  - typedef enum logic {SPI_IDLE, SPI_SHIFT} spi_state_t
  - byte index typedef sized clog2(AES_BLOCK_BYTES)
- Sub-module spi_sync_edge: parameterised-depth synchroniser plus rise/fall pulse outputs, with a reset-value parameter. Instantiated three times: sclk, ss_n (reset value 1), and mosi (level output only).

Test Plan:
- Reset, then ss_n low, then 8 SCK cycles with MOSI=0xA5 (clk:SCK = 8:1) -> one rx_valid pulse, rx_data=0xA5, byte_idx 0->1, block_done=0.
- Preload tx_data=0x3C, then select and clock 8 bits -> MISO samples at SCK rise read 0,0,1,1,1,1,0,0; tx_ready returns to 1 at ss_fall.
- 16 bytes 0x00..0x0F in one frame -> 16 rx_valid pulses; block_done only with byte 0x0F; byte_idx wraps to 0.
- Second byte clocked with no tx_load -> tx_underrun pulses once, MISO sends 0x00.
- ss_n deasserted after 5 bits -> no rx_valid, miso_oe=0. Next frame byte 0x81 is received correctly with byte_idx=0.
- tx_load pulses while tx_ready=0 (values 0x11, then 0x22) -> buffer keeps the first value, and the next byte transmits 0x11.
